// File: rtl/pll_seq_pkg.sv
// Shared types for the PLL power-up/recovery sequencer: state encoding, widths
// and the state-to-output decode.
package pll_seq_pkg;

   localparam int unsigned STATE_W = 3;
   localparam int unsigned RETRY_W = 2;

   typedef enum logic [STATE_W-1:0] {
      ST_HOLD      = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_STABLE    = 3'd2,
      ST_RUN       = 3'd3,
      ST_FAULT     = 3'd4
   } seq_state_e;

   typedef struct packed {
      logic pll_reset;
      logic sys_reset_n;
      logic pll_ready;
      logic fail;
   } seq_out_t;

   // Output levels owned by each state; applied to the state being entered
   function automatic seq_out_t decode_outputs(seq_state_e s);
      seq_out_t o;
      o.pll_reset   = (s == ST_HOLD) || (s == ST_FAULT);
      o.sys_reset_n = (s == ST_RUN);
      o.pll_ready   = (s == ST_RUN);
      o.fail        = (s == ST_FAULT);
      return o;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser with synchronous active-low clear.
module sync_2ff #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_meta;
   logic [WIDTH-1:0] r_sync;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_meta <= '0;
         r_sync <= '0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/pll_seq_ctrl.sv
// PLL power-up and recovery sequencer: drives PLL reset, qualifies lock, gates the
// system reset request. Optional lock-loss counter via PLL_SEQ_CTRL_LOSS_CNT_EN.
module pll_seq_ctrl
   import pll_seq_pkg::*;
#(
   parameter int unsigned RST_CYCLES    = 64,
   parameter int unsigned LOCK_TIMEOUT  = 27000,
   parameter int unsigned STABLE_CYCLES = 256,
   parameter int unsigned MAX_RETRIES   = 3,
   parameter int unsigned CNT_W         = 16
) (
   input  logic               clkin,
   input  logic               reset_n,
   input  logic               pll_lock,
   input  logic               relock_req,
   output logic               pll_reset,
   output logic               sys_reset_n,
   output logic               pll_ready,
   output logic               fail,
   output logic [STATE_W-1:0] state,
   output logic [RETRY_W-1:0] retry_cnt
`ifdef PLL_SEQ_CTRL_LOSS_CNT_EN
   ,
   output logic [7:0]         loss_cnt
`endif
);

   if (MAX_RETRIES > 3) begin : g_chk_retries
      $error("pll_seq_ctrl: MAX_RETRIES must fit in the 2-bit retry counter");
   end
   if (RST_CYCLES < 2) begin : g_chk_rst
      $error("pll_seq_ctrl: RST_CYCLES must be at least 2");
   end

   seq_state_e         r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [RETRY_W-1:0] r_retry;
   seq_out_t           r_out;

   seq_state_e         w_nxt_state;
   logic [CNT_W-1:0]   w_nxt_cnt;
   logic [CNT_W-1:0]   w_cnt_inc;
   logic [RETRY_W-1:0] w_nxt_retry;
   logic               w_lock_s;

   sync_2ff #(.WIDTH(1)) u_lock_sync (
      .i_clk   (clkin),
      .i_rst_n (reset_n),
      .i_d     (pll_lock),
      .o_q     (w_lock_s)
   );

   assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);

   // Transition logic; relock_req overrides every lock/timeout event
   always_comb begin
      w_nxt_state = r_state;
      w_nxt_cnt   = w_cnt_inc;
      w_nxt_retry = r_retry;
      if (relock_req) begin
         w_nxt_state = ST_HOLD;
         w_nxt_cnt   = '0;
         if (r_state == ST_FAULT) w_nxt_retry = '0;
      end else begin
         case (r_state)
            ST_HOLD: begin
               if (r_cnt == CNT_W'(RST_CYCLES - 1)) begin
                  w_nxt_state = ST_WAIT_LOCK;
                  w_nxt_cnt   = '0;
               end
            end
            ST_WAIT_LOCK: begin
               if (w_lock_s) begin
                  w_nxt_state = ST_STABLE;
                  w_nxt_cnt   = '0;
               end else if (r_cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
                  w_nxt_cnt = '0;
                  if (r_retry < RETRY_W'(MAX_RETRIES)) begin
                     w_nxt_retry = r_retry + RETRY_W'(1);
                     w_nxt_state = ST_HOLD;
                  end else begin
                     w_nxt_state = ST_FAULT;
                  end
               end
            end
            ST_STABLE: begin
               if (!w_lock_s) begin
                  w_nxt_state = ST_WAIT_LOCK;
                  w_nxt_cnt   = '0;
               end else if (r_cnt == CNT_W'(STABLE_CYCLES - 1)) begin
                  w_nxt_state = ST_RUN;
                  w_nxt_cnt   = '0;
                  w_nxt_retry = '0;
               end
            end
            ST_RUN: begin
               w_nxt_cnt = '0;
               if (!w_lock_s) w_nxt_state = ST_HOLD;
            end
            ST_FAULT: begin
               w_nxt_cnt = '0;
            end
            default: begin
               w_nxt_state = ST_HOLD;
               w_nxt_cnt   = '0;
            end
         endcase
      end
   end

   // Outputs are decoded from the next state so they move on the same edge as state
   always_ff @(posedge clkin) begin
      if (!reset_n) begin
         r_state <= ST_HOLD;
         r_cnt   <= '0;
         r_retry <= '0;
         r_out   <= decode_outputs(ST_HOLD);
      end else begin
         r_state <= w_nxt_state;
         r_cnt   <= w_nxt_cnt;
         r_retry <= w_nxt_retry;
         r_out   <= decode_outputs(w_nxt_state);
      end
   end

   assign pll_reset   = r_out.pll_reset;
   assign sys_reset_n = r_out.sys_reset_n;
   assign pll_ready   = r_out.pll_ready;
   assign fail        = r_out.fail;
   assign state       = r_state;
   assign retry_cnt   = r_retry;

`ifdef PLL_SEQ_CTRL_LOSS_CNT_EN
   logic [7:0] r_loss_cnt;
   logic       w_loss_evt;

   // Only a genuine lock drop out of RUN counts; a relock request does not
   assign w_loss_evt = (r_state == ST_RUN) && !relock_req && !w_lock_s;

   always_ff @(posedge clkin) begin
      if (!reset_n) begin
         r_loss_cnt <= '0;
      end else if (w_loss_evt && (r_loss_cnt != 8'hFF)) begin
         r_loss_cnt <= r_loss_cnt + 8'd1;
      end
   end

   assign loss_cnt = r_loss_cnt;
`endif

endmodule
